// File: rtl/sram_d_arbiter.sv
// Two-master OBI arbiter for the SRAM data port. It uses round-robin or fixed-priority
// selection, holds the request while the slave stalls, and routes responses in order.
module sram_d_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter bit FIXED_PRIO      = 1'b0,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             m0_req_i,
  output logic             m0_gnt_o,
  input  logic [31:0]      m0_addr_i,
  input  logic             m0_we_i,
  input  logic [3:0]       m0_be_i,
  input  logic [31:0]      m0_wdata_i,
  output logic             m0_rvalid_o,
  output logic [31:0]      m0_rdata_o,
  input  logic             m1_req_i,
  output logic             m1_gnt_o,
  input  logic [31:0]      m1_addr_i,
  input  logic             m1_we_i,
  input  logic [3:0]       m1_be_i,
  input  logic [31:0]      m1_wdata_i,
  output logic             m1_rvalid_o,
  output logic [31:0]      m1_rdata_o,
  output logic             s_req_o,
  input  logic             s_gnt_i,
  output logic [31:0]      s_addr_o,
  output logic             s_we_o,
  output logic [3:0]       s_be_o,
  output logic [31:0]      s_wdata_o,
  input  logic             s_rvalid_i,
  input  logic [31:0]      s_rdata_i,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             err_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic             live;
  logic             en;
  logic             lock_vld;
  logic             lock_id;
  logic             rr_last;
  logic             err_q;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             id_mem [MAX_OUTSTANDING];
  logic             head_id;
  logic             pop;
  logic             full_blk;
  logic             sel;
  logic             sel_req;
  logic             accept;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // Request selection, slave-side mux and response routing
  always_comb begin
    // live keeps every handshake output quiet for the first cycle after reset
    en       = live & ~rst_i;
    pop      = s_rvalid_i & (count != '0);
    full_blk = (count == CNT_W'(MAX_OUTSTANDING)) & ~pop;
    head_id  = id_mem[head];

    sel = 1'b0;
    if (lock_vld)                  sel = lock_id;
    else if (m0_req_i & ~m1_req_i) sel = 1'b0;
    else if (m1_req_i & ~m0_req_i) sel = 1'b1;
    else if (m0_req_i & m1_req_i)  sel = FIXED_PRIO ? 1'b0 : ~rr_last;

    sel_req   = sel ? m1_req_i   : m0_req_i;
    s_req_o   = en & sel_req & ~full_blk;
    s_addr_o  = sel ? m1_addr_i  : m0_addr_i;
    s_we_o    = sel ? m1_we_i    : m0_we_i;
    s_be_o    = sel ? m1_be_i    : m0_be_i;
    s_wdata_o = sel ? m1_wdata_i : m0_wdata_i;

    accept   = s_req_o & s_gnt_i;
    m0_gnt_o = accept & ~sel;
    m1_gnt_o = accept & sel;

    m0_rvalid_o = en & pop & ~head_id;
    m1_rvalid_o = en & pop & head_id;
    m0_rdata_o  = m0_rvalid_o ? s_rdata_i : '0;
    m1_rdata_o  = m1_rvalid_o ? s_rdata_i : '0;

    outstanding_o = count;
    err_o         = err_q;
  end

  // Control state: FIFO pointers/count, lock, round-robin, error flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      live     <= 1'b0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      lock_vld <= 1'b0;
      rr_last  <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      live <= 1'b1;
      if (s_req_o & ~s_gnt_i) lock_vld <= 1'b1;
      else if (accept)        lock_vld <= 1'b0;
      if (accept) begin
        rr_last <= sel;
        tail    <= ptr_inc(tail);
      end
      if (pop) head <= ptr_inc(head);
      if (s_rvalid_i & (count == '0)) err_q <= 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ID storage and locked master index carry no reset; they are qualified by count/lock_vld
  always_ff @(posedge clk_i) begin
    if (s_req_o & ~s_gnt_i) lock_id <= sel;
    if (accept) id_mem[tail] <= sel;
  end

endmodule

// File: tb/tb_sram_d_arbiter.sv
// Directed testbench for sram_d_arbiter: table-driven vectors on a round-robin instance
// plus hand sequences for reset, error recovery and fixed priority.
module tb_sram_d_arbiter;

  localparam logic [31:0] A0 = 32'h8000_0010;
  localparam logic [31:0] A1 = 32'h9000_0020;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req, s_gnt, s_rvalid;
  logic [31:0] s_rdata;
  logic [31:0] m0_addr = A0, m1_addr = A1;
  logic        m0_we = 1'b0, m1_we = 1'b1;
  logic [3:0]  m0_be = 4'hF, m1_be = 4'h3;
  logic [31:0] m0_wdata = 32'h0000_00A0, m1_wdata = 32'h0000_00B1;

  logic        a_g0, a_g1, a_rv0, a_rv1, a_sreq, a_swe, a_err;
  logic [31:0] a_rd0, a_rd1, a_saddr, a_swdata;
  logic [3:0]  a_sbe;
  logic [1:0]  a_out;

  logic        b_g0, b_g1, b_rv0, b_rv1, b_sreq, b_swe, b_err;
  logic [31:0] b_rd0, b_rd1, b_saddr, b_swdata;
  logic [3:0]  b_sbe;
  logic [1:0]  b_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_d_arbiter #(.MAX_OUTSTANDING(2), .FIXED_PRIO(1'b0)) u_rr (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_gnt_o(a_g0), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
    .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rvalid_o(a_rv0), .m0_rdata_o(a_rd0),
    .m1_req_i(m1_req), .m1_gnt_o(a_g1), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
    .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rvalid_o(a_rv1), .m1_rdata_o(a_rd1),
    .s_req_o(a_sreq), .s_gnt_i(s_gnt), .s_addr_o(a_saddr), .s_we_o(a_swe),
    .s_be_o(a_sbe), .s_wdata_o(a_swdata), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .outstanding_o(a_out), .err_o(a_err)
  );

  sram_d_arbiter #(.MAX_OUTSTANDING(2), .FIXED_PRIO(1'b1)) u_fp (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_gnt_o(b_g0), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
    .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rvalid_o(b_rv0), .m0_rdata_o(b_rd0),
    .m1_req_i(m1_req), .m1_gnt_o(b_g1), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
    .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rvalid_o(b_rv1), .m1_rdata_o(b_rd1),
    .s_req_o(b_sreq), .s_gnt_i(s_gnt), .s_addr_o(b_saddr), .s_we_o(b_swe),
    .s_be_o(b_sbe), .s_wdata_o(b_swdata), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .outstanding_o(b_out), .err_o(b_err)
  );

  typedef struct {
    logic        req0, req1, sgnt, srv;
    logic [31:0] rdata;
    logic        e_sreq, e_sel, e_g0, e_g1, e_rv0, e_rv1;
    logic [1:0]  e_out;
    logic        e_err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r0, r1, g, rv, input logic [31:0] rd,
                     input logic sreq, sel, g0, g1, rv0, rv1,
                     input logic [1:0] out, input logic err);
    vec_t v;
    v.req0 = r0; v.req1 = r1; v.sgnt = g; v.srv = rv; v.rdata = rd;
    v.e_sreq = sreq; v.e_sel = sel; v.e_g0 = g0; v.e_g1 = g1;
    v.e_rv0 = rv0; v.e_rv1 = rv1; v.e_out = out; v.e_err = err;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r0, r1, g, rv, input logic [31:0] rd);
    m0_req = r0; m1_req = r1; s_gnt = g; s_rvalid = rv; s_rdata = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    //   r0 r1 gnt rv rdata          sreq sel g0 g1 rv0 rv1 out err
    // m0 alone, four back-to-back reads
    add(1, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0, 2'd0, 0);
    add(1, 0, 1, 1, 32'h1111_0001,  1, 0, 1, 0, 1, 0, 2'd1, 0);
    add(1, 0, 1, 1, 32'h1111_0002,  1, 0, 1, 0, 1, 0, 2'd1, 0);
    add(1, 0, 1, 1, 32'h1111_0003,  1, 0, 1, 0, 1, 0, 2'd1, 0);
    add(0, 0, 1, 1, 32'h1111_0004,  0, 0, 0, 0, 1, 0, 2'd1, 0);
    // both request, round-robin alternation, responses to originator
    add(1, 1, 1, 0, 32'h0,          1, 1, 0, 1, 0, 0, 2'd0, 0);
    add(1, 1, 1, 1, 32'h2222_0001,  1, 0, 1, 0, 0, 1, 2'd1, 0);
    add(1, 1, 1, 1, 32'h2222_0002,  1, 1, 0, 1, 1, 0, 2'd1, 0);
    add(1, 1, 1, 1, 32'h2222_0003,  1, 0, 1, 0, 0, 1, 2'd1, 0);
    add(0, 0, 1, 1, 32'h2222_0004,  0, 0, 0, 0, 1, 0, 2'd1, 0);
    // fill to MAX_OUTSTANDING, block, then push+pop re-opens the slot
    add(1, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0, 2'd0, 0);
    add(1, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0, 2'd1, 0);
    add(1, 0, 1, 0, 32'h0,          0, 0, 0, 0, 0, 0, 2'd2, 0);
    add(1, 0, 1, 1, 32'h3333_0001,  1, 0, 1, 0, 1, 0, 2'd2, 0);
    add(0, 0, 1, 1, 32'h3333_0002,  0, 0, 0, 0, 1, 0, 2'd2, 0);
    add(0, 1, 1, 1, 32'h3333_0003,  1, 1, 0, 1, 1, 0, 2'd1, 0);
    add(0, 0, 1, 1, 32'h3333_0004,  0, 0, 0, 0, 0, 1, 2'd1, 0);
    // slave stall with m1 locked while m0 requests (m0 would win unlocked)
    add(0, 1, 0, 0, 32'h0,          1, 1, 0, 0, 0, 0, 2'd0, 0);
    add(1, 1, 0, 0, 32'h0,          1, 1, 0, 0, 0, 0, 2'd0, 0);
    add(1, 1, 0, 0, 32'h0,          1, 1, 0, 0, 0, 0, 2'd0, 0);
    add(1, 1, 1, 0, 32'h0,          1, 1, 0, 1, 0, 0, 2'd0, 0);
    add(1, 1, 1, 1, 32'h4444_0001,  1, 0, 1, 0, 0, 1, 2'd1, 0);
    add(0, 0, 1, 1, 32'h4444_0002,  0, 0, 0, 0, 1, 0, 2'd1, 0);
    // spurious response with an empty FIFO
    add(0, 0, 1, 1, 32'h5555_0001,  0, 0, 0, 0, 0, 0, 2'd0, 0);
    add(0, 0, 1, 0, 32'h0,          0, 0, 0, 0, 0, 0, 2'd0, 1);

    tick();
    tick();
    rst = 1'b0;
    // first cycle after reset: handshakes held low even with a request present
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    chk("post_rst_sreq", {31'b0, a_sreq}, 32'd0);
    chk("post_rst_gnt", {30'b0, a_g0, a_g1}, 32'd0);
    chk("post_rst_out", {30'b0, a_out}, 32'd0);
    chk("post_rst_err", {31'b0, a_err}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();

    foreach (vq[i]) begin
      drive(vq[i].req0, vq[i].req1, vq[i].sgnt, vq[i].srv, vq[i].rdata);
      #2;
      chk($sformatf("v%0d_sreq", i), {31'b0, a_sreq}, {31'b0, vq[i].e_sreq});
      chk($sformatf("v%0d_gnt", i), {30'b0, a_g0, a_g1}, {30'b0, vq[i].e_g0, vq[i].e_g1});
      chk($sformatf("v%0d_rvalid", i), {30'b0, a_rv0, a_rv1}, {30'b0, vq[i].e_rv0, vq[i].e_rv1});
      chk($sformatf("v%0d_rdata0", i), a_rd0, vq[i].e_rv0 ? vq[i].rdata : 32'h0);
      chk($sformatf("v%0d_rdata1", i), a_rd1, vq[i].e_rv1 ? vq[i].rdata : 32'h0);
      chk($sformatf("v%0d_out", i), {30'b0, a_out}, {30'b0, vq[i].e_out});
      chk($sformatf("v%0d_err", i), {31'b0, a_err}, {31'b0, vq[i].e_err});
      if (vq[i].e_sreq) begin
        chk($sformatf("v%0d_addr", i), a_saddr, vq[i].e_sel ? A1 : A0);
        chk($sformatf("v%0d_fields", i), {27'b0, a_swe, a_sbe},
            vq[i].e_sel ? {27'b0, 1'b1, 4'h3} : {27'b0, 1'b0, 4'hF});
        chk($sformatf("v%0d_wdata", i), a_swdata, vq[i].e_sel ? 32'hB1 : 32'hA0);
      end
      tick();
    end

    // one-cycle reset clears the sticky error; outputs quiet during reset
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    chk("in_rst_sreq", {31'b0, a_sreq}, 32'd0);
    chk("in_rst_gnt", {31'b0, a_g0}, 32'd0);
    tick();
    rst = 1'b0;
    chk("rst_err_clr", {31'b0, a_err}, 32'd0);
    chk("rst_out_clr", {30'b0, a_out}, 32'd0);
    chk("rst_fp_err_clr", {31'b0, b_err}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();

    // fixed priority: m0 wins three contended cycles, m1 granted when m0 drops
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    chk("fp_c1_gnt", {30'b0, b_g0, b_g1}, 32'd2);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h6666_0001);
    #1;
    chk("fp_c2_gnt", {30'b0, b_g0, b_g1}, 32'd2);
    chk("fp_c2_rd0", b_rd0, 32'h6666_0001);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h6666_0002);
    #1;
    chk("fp_c3_gnt", {30'b0, b_g0, b_g1}, 32'd2);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h6666_0003);
    #1;
    chk("fp_c4_gnt", {30'b0, b_g0, b_g1}, 32'd1);
    chk("fp_c4_rv", {30'b0, b_rv0, b_rv1}, 32'd2);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h6666_0004);
    #1;
    chk("fp_c5_rv", {30'b0, b_rv0, b_rv1}, 32'd1);
    chk("fp_c5_rd1", b_rd1, 32'h6666_0004);
    chk("fp_c5_rd0", b_rd0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("fp_drained", {30'b0, b_out}, 32'd0);
    chk("fp_no_err", {31'b0, b_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
